// File: rtl/mcp_rx_packet_arbiter_pkg.sv
// Shared types for the hydra receive concentrator.
//   packet_declare_e : LArPix packet type carried in bits [1:0]
//   arb_state_e      : arbiter sequencing states
//   field offsets    : chip/channel/regmap fields inside a 63-bit packet
package mcp_rx_packet_arbiter_pkg;

  typedef enum logic [1:0] {
    PKT_DATA   = 2'd0,
    PKT_TEST   = 2'd1,
    PKT_CFG_WR = 2'd2,
    PKT_CFG_RD = 2'd3
  } packet_declare_e;

  localparam int TYPE_LSB        = 0;
  localparam int TYPE_W          = 2;
  localparam int CHIP_ID_LSB     = 2;
  localparam int CHIP_ID_W       = 8;
  localparam int CHANNEL_ID_LSB  = 10;
  localparam int CHANNEL_ID_W    = 6;
  localparam int REGMAP_ADDR_LSB = 10;
  localparam int REGMAP_ADDR_W   = 8;
  localparam int REGMAP_DATA_LSB = 18;
  localparam int REGMAP_DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNLOAD,
    ST_CAPTURE,
    ST_PUSH
  } arb_state_e;

  function automatic packet_declare_e pkt_type(input logic [TYPE_W-1:0] lsbs);
    return packet_declare_e'(lsbs);
  endfunction

endpackage

// File: rtl/mcp_rx_packet_arbiter_if.sv
// Receiver-side handshake and packet output stream of the concentrator.
//   rx_empty/rx_data/parity_error/uld_rx_data : per-channel uart_rx_fpga handshake
//   pkt_valid/pkt_ready/pkt_data/pkt_ch/pkt_par_err : FWFT packet stream to the host
// master = the arbiter, slave = receivers plus packet consumer.
interface mcp_rx_packet_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 64
);
  logic [NUM_CH-1:0]           rx_empty;
  logic [NUM_CH*(WIDTH-1)-1:0] rx_data;
  logic [NUM_CH-1:0]           parity_error;
  logic [NUM_CH-1:0]           uld_rx_data;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [WIDTH-2:0]            pkt_data;
  logic [$clog2(NUM_CH):0]     pkt_ch;
  logic                        pkt_par_err;

  modport master (
    input  rx_empty, rx_data, parity_error, pkt_ready,
    output uld_rx_data, pkt_valid, pkt_data, pkt_ch, pkt_par_err
  );

  modport slave (
    output rx_empty, rx_data, parity_error, pkt_ready,
    input  uld_rx_data, pkt_valid, pkt_data, pkt_ch, pkt_par_err
  );
endinterface

// File: rtl/mcp_rx_packet_arbiter_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en/wr_data: write (ignored when full)
//   rd_en        : pop the head (ignored when empty)
//   rd_data      : head entry, zero while empty
//   valid/full   : non-empty / full flags
//   level        : occupancy 0..DEPTH
module mcp_rx_packet_arbiter_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign valid = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && valid;
  // Zero head while empty so the output is defined straight out of reset.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/mcp_rx_packet_arbiter.sv
// Round-robin receive concentrator for hydra LArPix readout.
//   clk, reset_n : core clock, synchronous active-low reset
//   bus          : receiver handshake + FWFT packet stream (master side)
//   type_mask    : bit k accepts packet type k
//   drop_bad_par : discard packets flagged with a parity error
//   cnt_clr      : clear all statistics counters
//   fifo_level   : output FIFO occupancy
//   type_cnt     : accepted packets per type (type0 in LSBs), saturating
//   par_err_cnt  : packets seen with parity error, saturating
//   drop_cnt     : packets discarded, saturating
//
// state      | meaning
// ST_IDLE    | wait for a requester and FIFO room, pick round-robin grant
// ST_UNLOAD  | uld_rx_data strobe to the granted receiver
// ST_CAPTURE | receiver output settles; latch data and parity at exit edge
// ST_PUSH    | classify, write FIFO or drop, update counters, advance rr
module mcp_rx_packet_arbiter
  import mcp_rx_packet_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  mcp_rx_packet_arbiter_if.master       bus,
  input  logic [3:0]                    type_mask,
  input  logic                          drop_bad_par,
  input  logic                          cnt_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [4*CNT_WIDTH-1:0]        type_cnt,
  output logic [CNT_WIDTH-1:0]          par_err_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);
  localparam int PW  = WIDTH - 1;
  localparam int CHW = $clog2(NUM_CH) + 1;
  localparam int EW  = CHW + 1 + PW;

  arb_state_e       state;
  logic [CHW-1:0]   rr_ptr, grant, pick, pick_hi, pick_lo;
  logic             hi_found, lo_found, req_any;
  logic [NUM_CH-1:0] uld;
  logic [PW-1:0]    sel_data, cap_data;
  logic             sel_par, cap_par;
  packet_declare_e  cap_type;
  logic             accept, push;
  logic             fifo_full, fifo_valid;
  logic [EW-1:0]    fifo_dout;
  logic [CNT_WIDTH-1:0] type_cnt_r [4];

  // Round robin: lowest requester at/after rr_ptr wins, else lowest below it.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!bus.rx_empty[i]) begin
        if (CHW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          pick_hi  = CHW'(i);
        end else begin
          lo_found = 1'b1;
          pick_lo  = CHW'(i);
        end
      end
    end
    req_any = hi_found || lo_found;
    pick    = hi_found ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_data = '0;
    sel_par  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CHW'(i)) begin
        sel_data = bus.rx_data[i*PW +: PW];
        sel_par  = bus.parity_error[i];
      end
    end
  end

  assign cap_type = pkt_type(cap_data[TYPE_LSB +: TYPE_W]);
  assign accept   = type_mask[cap_type] && !(drop_bad_par && cap_par);
  assign push     = (state == ST_PUSH) && accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      uld      <= '0;
      cap_data <= '0;
      cap_par  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Full check here is the only write guard: one packet in flight at most.
          if (req_any && !fifo_full) begin
            grant <= pick;
            uld   <= NUM_CH'(1) << pick;
            state <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          uld   <= '0;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          cap_data <= sel_data;
          cap_par  <= sel_par;
          state    <= ST_PUSH;
        end
        ST_PUSH: begin
          rr_ptr <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr) begin
      for (int i = 0; i < 4; i++) type_cnt_r[i] <= '0;
      par_err_cnt <= '0;
      drop_cnt    <= '0;
    end else if (state == ST_PUSH) begin
      if (accept && type_cnt_r[cap_type] != '1)
        type_cnt_r[cap_type] <= type_cnt_r[cap_type] + 1'b1;
      if (!accept && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      if (cap_par && par_err_cnt != '1)
        par_err_cnt <= par_err_cnt + 1'b1;
    end
  end

  always_comb begin
    type_cnt = '0;
    for (int i = 0; i < 4; i++) type_cnt[i*CNT_WIDTH +: CNT_WIDTH] = type_cnt_r[i];
  end

  mcp_rx_packet_arbiter_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data ({grant, cap_par, cap_data}),
    .rd_en   (bus.pkt_ready),
    .rd_data (fifo_dout),
    .valid   (fifo_valid),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign bus.uld_rx_data = uld;
  assign bus.pkt_valid   = fifo_valid;
  assign {bus.pkt_ch, bus.pkt_par_err, bus.pkt_data} = fifo_dout;
endmodule

// File: tb/tb_mcp_rx_packet_arbiter.sv
module tb_mcp_rx_packet_arbiter;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 64;
  localparam int DEPTH  = 16;
  localparam int CW     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [3:0]  type_mask = 4'b1111;
  logic        drop_bad_par = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] type_cnt;
  logic [3:0]  par_err_cnt, drop_cnt;

  mcp_rx_packet_arbiter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  mcp_rx_packet_arbiter #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .type_mask    (type_mask),
    .drop_bad_par (drop_bad_par),
    .cnt_clr      (cnt_clr),
    .fifo_level   (fifo_level),
    .type_cnt     (type_cnt),
    .par_err_cnt  (par_err_cnt),
    .drop_cnt     (drop_cnt)
  );

  // Receiver model: queued packets; unload moves head into the output register.
  logic [3:0]  tb_empty = 4'b1111;
  logic [3:0]  tb_par = 4'b0000;
  logic [62:0] rx_reg [4] = '{default: '0};
  logic        tb_ready = 1'b0;
  logic [62:0] qd [4][32];
  logic        qp [4][32];
  int          qw [4] = '{default: 0};
  int          qr [4] = '{default: 0};

  assign bus.rx_empty     = tb_empty;
  assign bus.parity_error = tb_par;
  assign bus.rx_data      = {rx_reg[3], rx_reg[2], rx_reg[1], rx_reg[0]};
  assign bus.pkt_ready    = tb_ready;

  logic [62:0] out_data [256];
  logic [2:0]  out_ch [256];
  logic        out_par [256];
  int          glog [256];
  int n_out = 0, n_g = 0, n_uld = 0, n_uld_full = 0;

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (!reset_n) begin
        qr[c] = qw[c];
        rx_reg[c] = '0;
        tb_par[c] = 1'b0;
      end else if (bus.uld_rx_data[c] && qr[c] != qw[c]) begin
        rx_reg[c] = qd[c][qr[c] % 32];
        tb_par[c] = qp[c][qr[c] % 32];
        qr[c]++;
      end
      tb_empty[c] = (qr[c] == qw[c]);
    end
    if (bus.uld_rx_data != 4'b0000) begin
      n_uld++;
      if (fifo_level == 5'd16) n_uld_full++;
      for (int c = 0; c < 4; c++)
        if (bus.uld_rx_data[c] && n_g < 256) begin
          glog[n_g] = c;
          n_g++;
        end
    end
    if (bus.pkt_valid && tb_ready && n_out < 256) begin
      out_data[n_out] = bus.pkt_data;
      out_ch[n_out]   = bus.pkt_ch;
      out_par[n_out]  = bus.pkt_par_err;
      n_out++;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input int c, input logic [62:0] d, input logic p);
    qd[c][qw[c] % 32] = d;
    qp[c][qw[c] % 32] = p;
    qw[c]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_out(input string tag, input int target, input int budget);
    for (int t = 0; t < budget && n_out < target; t++) @(negedge clk);
    @(negedge clk);
    chk(tag, 64'(n_out), 64'(target));
  endtask

  int ob, gb, u0, uf0;

  initial begin
    // reset state
    do_reset();
    chk("rst_uld", 64'(bus.uld_rx_data), 64'h0);
    chk("rst_valid", 64'(bus.pkt_valid), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_data", 64'(bus.pkt_data), 64'h0);
    chk("rst_cnts", {40'h0, type_cnt, par_err_cnt, drop_cnt}, 64'h0);

    // 1: single packet on ch2, latency
    @(posedge clk); #2;
    offer(2, 63'h2A, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_uld_on", 64'(bus.uld_rx_data), 64'h4);
    @(negedge clk);
    chk("t1_uld_off", 64'(bus.uld_rx_data), 64'h0);
    chk("t1_valid_n1", 64'(bus.pkt_valid), 64'h0);
    @(negedge clk);
    chk("t1_valid_n2", 64'(bus.pkt_valid), 64'h0);
    @(negedge clk);
    chk("t1_valid_n3", 64'(bus.pkt_valid), 64'h1);
    chk("t1_data", 64'(bus.pkt_data), 64'h2A);
    chk("t1_ch", 64'(bus.pkt_ch), 64'h2);
    chk("t1_par", 64'(bus.pkt_par_err), 64'h0);
    chk("t1_level", 64'(fifo_level), 64'h1);
    chk("t1_type2", 64'(type_cnt[11:8]), 64'h1);
    ob = n_out;
    @(posedge clk); #2 tb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_pop_valid", 64'(bus.pkt_valid), 64'h0);
    chk("t1_pop_level", 64'(fifo_level), 64'h0);
    chk("t1_pop_data", 64'(out_data[ob]), 64'h2A);

    // 2: fairness, 4 packets per channel, all type0 -> saturation at 15
    do_reset();
    ob = n_out;
    gb = n_g;
    @(posedge clk); #2;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) offer(c, 63'((c * 16 + k) * 4), 1'b0);
    wait_out("t2_count", ob + 16, 200);
    for (int i = 0; i < 16; i++) begin
      chk("t2_grant", 64'(glog[gb + i]), 64'(i % 4));
      chk("t2_ch", 64'(out_ch[ob + i]), 64'(i % 4));
      chk("t2_data", 64'(out_data[ob + i]), 64'(((i % 4) * 16 + i / 4) * 4));
    end
    chk("t2_type0_sat", 64'(type_cnt[3:0]), 64'hF);
    @(posedge clk); #2;
    offer(1, 63'h400, 1'b0);
    wait_out("t2_count17", ob + 17, 40);
    chk("t2_type0_sat17", 64'(type_cnt[3:0]), 64'hF);
    chk("t2_data17", 64'(out_data[ob + 16]), 64'h400);
    @(posedge clk); #2 cnt_clr = 1'b1;
    @(posedge clk); #2 cnt_clr = 1'b0;
    @(negedge clk);
    chk("t2_clr", 64'(type_cnt), 64'h0);

    // 3: type filter
    @(posedge clk); #2 tb_ready = 1'b0;
    type_mask = 4'b1110;
    do_reset();
    @(posedge clk); #2;
    offer(0, 63'h100, 1'b0);
    offer(0, 63'h203, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3_level", 64'(fifo_level), 64'h1);
    chk("t3_data", 64'(bus.pkt_data), 64'h203);
    chk("t3_ch", 64'(bus.pkt_ch), 64'h0);
    chk("t3_drop", 64'(drop_cnt), 64'h1);
    chk("t3_type0", 64'(type_cnt[3:0]), 64'h0);
    chk("t3_type3", 64'(type_cnt[15:12]), 64'h1);

    // 4: parity handling
    type_mask = 4'b1111;
    drop_bad_par = 1'b0;
    do_reset();
    @(posedge clk); #2;
    offer(1, 63'h5, 1'b1);
    repeat (10) @(negedge clk);
    chk("t4_level_a", 64'(fifo_level), 64'h1);
    chk("t4_parflag", 64'(bus.pkt_par_err), 64'h1);
    chk("t4_ch", 64'(bus.pkt_ch), 64'h1);
    chk("t4_parcnt_a", 64'(par_err_cnt), 64'h1);
    chk("t4_drop_a", 64'(drop_cnt), 64'h0);
    @(posedge clk); #2;
    drop_bad_par = 1'b1;
    offer(1, 63'h9, 1'b1);
    repeat (10) @(negedge clk);
    chk("t4_level_b", 64'(fifo_level), 64'h1);
    chk("t4_parcnt_b", 64'(par_err_cnt), 64'h2);
    chk("t4_drop_b", 64'(drop_cnt), 64'h1);
    chk("t4_type1", 64'(type_cnt[7:4]), 64'h1);
    drop_bad_par = 1'b0;

    // 5: backpressure with 20 packets into a 16-deep FIFO
    do_reset();
    ob = n_out;
    u0 = n_uld;
    uf0 = n_uld_full;
    @(posedge clk); #2;
    for (int n = 0; n < 20; n++) offer(n % 4, 63'h1000 + 63'(n), 1'b0);
    for (int t = 0; t < 150 && fifo_level != 5'd16; t++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("t5_full_level", 64'(fifo_level), 64'd16);
    chk("t5_uld_total", 64'(n_uld - u0), 64'd16);
    chk("t5_uld_full", 64'(n_uld_full - uf0), 64'd0);
    @(posedge clk); #2 tb_ready = 1'b1;
    wait_out("t5_count", ob + 20, 200);
    for (int i = 0; i < 20; i++) begin
      chk("t5_data", 64'(out_data[ob + i]), 64'h1000 + 64'(i));
      chk("t5_ch", 64'(out_ch[ob + i]), 64'(i % 4));
    end
    chk("t5_level_end", 64'(fifo_level), 64'h0);
    chk("t5_drop", 64'(drop_cnt), 64'h0);

    // 6: reset during UNLOAD
    @(posedge clk); #2 tb_ready = 1'b0;
    do_reset();
    @(posedge clk); #2;
    offer(3, 63'h7, 1'b1);
    repeat (10) @(negedge clk);
    chk("t6_pre_level", 64'(fifo_level), 64'h1);
    chk("t6_pre_type3", 64'(type_cnt[15:12]), 64'h1);
    @(posedge clk); #2;
    offer(3, 63'hB, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_uld_on", 64'(bus.uld_rx_data), 64'h8);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_uld_rst", 64'(bus.uld_rx_data), 64'h0);
    chk("t6_valid_rst", 64'(bus.pkt_valid), 64'h0);
    chk("t6_level_rst", 64'(fifo_level), 64'h0);
    chk("t6_cnts_rst", {40'h0, type_cnt, par_err_cnt, drop_cnt}, 64'h0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_abandon_level", 64'(fifo_level), 64'h0);
    chk("t6_abandon_valid", 64'(bus.pkt_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
